// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch queue.
// Holds the queue entry layout used by storage and control.
package fetch_pkg;

    localparam int          FQ_DEPTH_DEF = 4;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc_incr;
    } fq_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Instruction-memory and IF/ID handshake bundle of the fetch queue.
// master = fetch queue side, slave = memory / decode side.
interface fetch_queue_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc_incr;
    logic        out_ready;

    modport master (
        output imem_req, imem_addr,
        input  imem_valid, imem_rdata,
        output out_valid, out_instr, out_pc_incr,
        input  out_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_valid, imem_rdata,
        input  out_valid, out_instr, out_pc_incr,
        output out_ready
    );

endinterface

// File: rtl/fq_storage.sv
// Circular entry store of the fetch queue: entries, head/tail, count.
// flush empties the queue and takes priority over push and pop.
module fq_storage
    import fetch_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH_DEF,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    input  logic           push,
    input  logic           pop,
    input  fq_entry_t      push_data,
    output fq_entry_t      head_data,
    output logic [CW-1:0]  count
);

    fq_entry_t     mem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;

    assign head_data = mem[head];

    // pointer and occupancy update; pointers wrap by width
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + PW'(1);
            if (pop)  head <= head + PW'(1);
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // entry write at tail; contents need no reset
    always_ff @(posedge clk) begin
        if (push && !flush && !rst) mem[tail] <= push_data;
    end

endmodule

// File: rtl/fetch_queue.sv
// Fetch queue: one outstanding imem request, redirect flush/discard.
// FETCHQ_PERF_EN adds saturating flush_cnt / starve_cnt counters.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int          FQ_DEPTH = FQ_DEPTH_DEF,
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    localparam int CW = $clog2(FQ_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          redirect,
    input  logic [31:0]   redirect_pc,
`ifdef FETCHQ_PERF_EN
    output logic [15:0]   flush_cnt,
    output logic [15:0]   starve_cnt,
`endif
    fetch_queue_if.master bus
);

    logic          pending;
    logic          discard;
    logic [31:0]   fetch_pc;
    logic [31:0]   req_pc_incr;
    logic          push;
    logic          pop;
    logic          issue;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    fq_entry_t     head;
    fq_entry_t     push_data;

    assign push = bus.imem_valid & pending & !discard & !redirect & !rst;
    assign pop  = bus.out_valid & bus.out_ready & !redirect;

    // occupancy after this cycle's push/pop, used to gate issue
    always_comb begin
        count_next = count;
        if (push && !pop)      count_next = count + CW'(1);
        else if (!push && pop) count_next = count - CW'(1);
    end

    assign issue = !rst && !redirect && !discard
                && (!pending || bus.imem_valid)
                && (count_next < CW'(FQ_DEPTH));

    assign push_data.instr   = bus.imem_rdata;
    assign push_data.pc_incr = req_pc_incr;

    assign bus.imem_req    = issue;
    assign bus.imem_addr   = rst ? RESET_PC : fetch_pc;
    assign bus.out_valid   = (count != '0) && !rst;
    assign bus.out_instr   = bus.out_valid ? head.instr : '0;
    assign bus.out_pc_incr = bus.out_valid ? head.pc_incr : '0;

    fq_storage #(.DEPTH(FQ_DEPTH)) u_storage (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect),
        .push      (push),
        .pop       (pop),
        .push_data (push_data),
        .head_data (head),
        .count     (count)
    );

    // request tracking: pending/discard flags and fetch address
    always_ff @(posedge clk) begin
        if (rst) begin
            pending     <= 1'b0;
            discard     <= 1'b0;
            fetch_pc    <= RESET_PC;
            req_pc_incr <= '0;
        end else if (redirect) begin
            fetch_pc <= redirect_pc;
            pending  <= pending & !bus.imem_valid;
            discard  <= pending & !bus.imem_valid;
        end else if (issue) begin
            pending     <= 1'b1;
            discard     <= 1'b0;
            fetch_pc    <= fetch_pc + 32'd4;
            req_pc_incr <= fetch_pc + 32'd4;
        end else if (pending && bus.imem_valid) begin
            pending <= 1'b0;
            discard <= 1'b0;
        end
    end

`ifdef FETCHQ_PERF_EN
    // saturating redirect and consumer-starvation counters
    always_ff @(posedge clk) begin
        if (rst) begin
            flush_cnt  <= '0;
            starve_cnt <= '0;
        end else begin
            if (redirect && flush_cnt != 16'hFFFF)
                flush_cnt <= flush_cnt + 16'd1;
            if (bus.out_ready && !bus.out_valid && starve_cnt != 16'hFFFF)
                starve_cnt <= starve_cnt + 16'd1;
        end
    end
`else
    // build without performance counters
`endif

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter FQ_DEPTH, default 4, number of queue entries; power of two, >= 2.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 redirect  input  1  branch/jump taken; flush queue, restart fetch.
REQ-006 redirect_pc  input  32  new fetch address, sampled when redirect=1.
REQ-007 imem_req  output  1  one-cycle instruction-memory read request.
REQ-008 imem_addr  output  32  word address of request, valid while imem_req=1.
REQ-009 imem_valid  input  1  read response strobe, arriving 1 or more cycles after imem_req.
REQ-010 imem_rdata  input  32  instruction word, valid with imem_valid.
REQ-011 out_valid  output  1  queue head valid toward IF/ID register.
REQ-012 out_instr  output  32  head instruction.
REQ-013 out_pc_incr  output  32  head fetch address + 4.
REQ-014 out_ready  input  1  consumer accepts head this cycle (IF/ID enable).

Function
REQ-015 Queue SHALL be a circular FIFO of {instr, pc_incr}, with head/tail pointers wrapping mod FQ_DEPTH and a count in 0..FQ_DEPTH.
REQ-016 out_valid SHALL equal (count != 0); out_instr/out_pc_incr SHALL be head entry, driven from registers only.
REQ-017 Pop SHALL occur when out_valid & out_ready; out_ready while empty SHALL have no effect.
REQ-018 At most one request SHALL be outstanding (pending flag).
REQ-019 imem_req SHALL assert when !rst & !redirect & !discard & (!pending | imem_valid) & (count_next < FQ_DEPTH), where count_next = count + push - pop.
REQ-020 imem_addr SHALL equal fetch_pc; fetch_pc SHALL advance by 4 on each issued request, wrapping modulo 2^32.
REQ-021 Response with pending & !discard & !redirect SHALL push {imem_rdata, addr_of_request + 4} at tail.
REQ-022 Push and pop in the same cycle SHALL leave count unchanged; push SHALL never overflow, by REQ-019.
REQ-023 Latency: request in cycle N with response in cycle N+k SHALL give out_valid in cycle N+k+1 when the queue was empty.
REQ-024 Redirect SHALL take priority over push, pop, and issue in the same cycle: count=0, head=tail=0, fetch_pc=redirect_pc.
REQ-025 Redirect with pending & !imem_valid SHALL set discard; the next imem_valid SHALL be dropped, clearing pending and discard.
REQ-026 Redirect coincident with imem_valid SHALL drop that response and leave discard clear.
REQ-027 First request after redirect SHALL be issued the cycle after redirect, or the cycle after the discarded response.
REQ-028 imem_valid with !pending SHALL be ignored.

Reset
REQ-029 rst=1 SHALL set count=0, head=tail=0, pending=0, discard=0, fetch_pc=RESET_PC.
REQ-030 Under rst, outputs SHALL be out_valid=0, out_instr=0, out_pc_incr=0, imem_req=0, imem_addr=RESET_PC.
REQ-031 rst mid-transfer SHALL abandon the outstanding request; a response arriving after reset release SHALL be ignored per REQ-028.
REQ-032 First request SHALL issue in the first cycle with rst=0.

Configuration
REQ-033 Macro FETCHQ_PERF_EN defined SHALL add outputs flush_cnt (16, count of redirect cycles) and starve_cnt (16, cycles with out_ready & !out_valid).
REQ-034 Both counters SHALL saturate at 16'hFFFF and reset to 0.
REQ-035 Macro FETCHQ_PERF_EN undefined SHALL give no counter ports or logic, with all other behaviour identical.

Structure
REQ-036 Shared package fetch_pkg SHALL hold FQ_DEPTH default, RESET_PC default, and the fq_entry_t {instr[31:0], pc_incr[31:0]} typedef.
REQ-037 Entry storage and pointers SHALL be sub-module fq_storage; control (pending, discard, fetch_pc, issue) SHALL reside in fetch_queue.

Verification
REQ-038 Reset release, 1-cycle memory, out_ready=1 -> imem_addr 0,4,8,...; out_pc_incr 4,8,12 in order, no gaps after the first entry.
REQ-039 out_ready=0 with 1-cycle memory -> exactly 4 entries queued, imem_req stays 0; a single out_ready pulse -> one pop, then one new request.
REQ-040 Redirect to 32'h0000_0100 with a request pending and the response 3 cycles later -> response dropped, next imem_addr=0x100, first out_pc_incr=0x104.
REQ-041 Redirect coincident with imem_valid and pop on a full queue -> count=0, out_valid=0 next cycle, no stale entry ever presented.
REQ-042 fetch_pc=32'hFFFF_FFFC -> next imem_addr=0, out_pc_incr=0 for that entry.
REQ-043 FETCHQ_PERF_EN defined, 3 redirects and 5 starve cycles -> flush_cnt=3, starve_cnt=5; rst -> both 0.
